// File: rtl/uart_rx.sv
// uart_rx: UART receiver for the uart_tx link.
// Frame on RxD: start bit, DATA_WIDTH data bits MSB first, parity bit, stop bit.
// Each bit is sampled once at its centre. The received word and its parity and
// framing flags are presented together with a one-cycle valid strobe.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RxD,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  valid,
   output logic                  parity_error,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int IDX_W          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic             P_ODD    = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Synchronizer flops idle high so reset never looks like a start bit
   logic r_sync1;
   logic r_sync2;
   logic w_rx_s;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_perr;
   logic                  r_ferr;
   logic                  r_busy;

   state_t                w_state_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [IDX_W-1:0]      w_idx_next;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  w_par_next;
   logic [DATA_WIDTH-1:0] w_data_next;
   logic                  w_valid_next;
   logic                  w_perr_next;
   logic                  w_ferr_next;
   logic                  w_busy_next;

   // Two-flop synchronizer bringing the asynchronous RxD into the clk domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RxD;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   // State, counters, shift register and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_shift <= w_shift_next;
         r_par   <= w_par_next;
         r_data  <= w_data_next;
         r_valid <= w_valid_next;
         r_perr  <= w_perr_next;
         r_ferr  <= w_ferr_next;
         r_busy  <= w_busy_next;
      end
   end

   // Next-state logic: half-bit wait to the start-bit centre, then whole bits
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_par_next   = r_par;
      w_data_next  = r_data;
      w_valid_next = 1'b0;
      w_perr_next  = r_perr;
      w_ferr_next  = r_ferr;

      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (!w_rx_s) begin
               w_state_next = START;
            end
         end

         START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_next = '0;
               if (!w_rx_s) begin
                  w_state_next = DATA;
                  w_idx_next   = '0;
               end else begin
                  // Line went high again before the centre: glitch, not a start
                  w_state_next = IDLE;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_next   = '0;
               // MSB arrives first, so shifting in at the LSB leaves it on top
               w_shift_next = DATA_WIDTH'({r_shift, w_rx_s});
               w_idx_next   = r_idx + IDX_W'(1);
               if (r_idx == IDX_LAST) begin
                  w_state_next = PARITY;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         PARITY: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_next   = '0;
               w_par_next   = w_rx_s;
               w_state_next = STOP;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (r_cnt == CNT_LAST) begin
               // Leaving at mid-stop-bit allows a following start bit with no gap
               w_cnt_next   = '0;
               w_data_next  = r_shift;
               w_perr_next  = (r_par != ((^r_shift) ^ P_ODD));
               w_ferr_next  = ~w_rx_s;
               w_valid_next = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase

      w_busy_next = (w_state_next != IDLE);
   end

   assign RxData       = r_data;
   assign valid        = r_valid;
   assign parity_error = r_perr;
   assign frame_error  = r_ferr;
   assign busy         = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver with error detection. It is the receive end of the link driven by uart_tx. It deserializes an 11-bit frame from the serial line RxD: start bit, DATA_WIDTH data bits, parity bit, stop bit. Data is sent MSB first, matching uart_tx frame ordering. It presents the received word with parity and framing error flags and a one-cycle valid strobe, for the system-level loopback and error-detection path.

Parameters:
DATA_WIDTH, 8, payload width in bits
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line bit rate
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data); 1 = odd parity (inverted XOR)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
RxD  input  1  serial line, idle high, asynchronous to clk
RxData  output  DATA_WIDTH  last received word, held until next frame completes
valid  output  1  one-cycle pulse: RxData and error flags updated
parity_error  output  1  received parity bit mismatched, held with RxData
frame_error  output  1  stop bit sampled low, held with RxData
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Constants:
  - CYCLES_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide; 868 at defaults).
  - HALF_BIT = CYCLES_PER_BIT/2 (434).
- Synchronizer:
  - RxD passes through a 2-flop synchronizer; the sync flops reset to 1.
  - All decisions use the synchronized value rx_s.
- Reset (asynchronous, any state):
  - state = IDLE; counters = 0.
  - RxData = 0, valid = 0, parity_error = 0, frame_error = 0, busy = 0.
  - A frame in progress is discarded; no valid is produced for it.
- Bit counter:
  - Counter cnt is wide enough for CYCLES_PER_BIT-1.
  - Bit index idx counts 0..DATA_WIDTH-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt==HALF_BIT-1, sample rx_s.
    - Low: go to DATA with cnt=0, idx=0.
    - High: false start; return to IDLE with no outputs changed.
  - DATA: when cnt==CYCLES_PER_BIT-1, shift rx_s into the shift register LSB side (first bit ends in MSB), then cnt=0, idx++.
    - After idx==DATA_WIDTH-1 is sampled, go to PARITY.
  - PARITY: when cnt==CYCLES_PER_BIT-1, capture the parity bit and go to STOP with cnt=0.
  - STOP: when cnt==CYCLES_PER_BIT-1, sample the stop bit. In the same edge:
    - RxData <= shift register.
    - parity_error <= (captured parity != XOR(data) ^ PARITY_ODD).
    - frame_error <= ~rx_s.
    - valid <= 1.
    - state <= IDLE.
- Output timing:
  - valid is high for exactly one cycle, the cycle after the stop-bit mid-sample.
  - Error flags and RxData are stable in the valid cycle and hold until the next valid.
- Sampling and return to IDLE:
  - Every sample is taken at bit centre.
  - The return to IDLE at mid-stop-bit lets back-to-back frames with zero idle gap be received.
- Frame errors:
  - If the stop bit is low (frame_error=1), IDLE sees rx_s==0 and immediately starts a new frame attempt. This is the required behaviour; no break detection.
- busy:
  - Registered: it is 1 in START/DATA/PARITY/STOP and 0 in IDLE, including the valid cycle.
- RxD changes mid-bit outside sample points are ignored.
- Latency: last stop-bit centre to valid = 1 clk, plus 2 clk synchronizer delay relative to the RxD pin.

Test Plan:
- Drive frame 0xA5 with even parity bit 0, stop 1, at 868 clk/bit -> one valid pulse, RxData=0xA5, parity_error=0, frame_error=0, busy=0 after.
- Drive 0xA5 with parity bit 1 -> valid, RxData=0xA5, parity_error=1, frame_error=0.
- Drive 0x3C with correct parity, stop bit 0 -> valid, RxData=0x3C, frame_error=1. Then hold RxD high for 2 bit times -> busy returns to 0 via false start, no extra valid.
- RxD low glitch of 100 clk -> busy pulses high, returns to IDLE at the START half-bit check, no valid, RxData unchanged.
- Assert reset for 1 clk during data bit 4 of frame 0xFF -> all outputs 0 immediately. A subsequent frame 0x01 is received correctly with no valid for the aborted frame.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses with matching RxData and all error flags 0. Compare against uart_tx driving RxD in loopback for 10 random words.
